// File: rtl/bcd_updown_counter_display.sv
// bcd_updown_counter_display
//   Up/down decimal counter (0..MAX_VAL) advanced by a prescaled tick, with a
//   sequential shift-add-3 binary-to-BCD converter and a digit multiplexer
//   feeding a seven-segment driver.
// Ports:
//   i_clk          system clock, all logic on posedge
//   i_reset        synchronous, active-high reset
//   i_en           1 = count on tick, 0 = hold (prescalers keep running)
//   i_up_dn        1 = increment, 0 = decrement
//   i_load         level; loads i_load_val (saturated to MAX_VAL), clears tick prescaler
//   i_load_val     preset value, zero-extended
//   o_count_bin    current binary count
//   o_bcd_out      last completed BCD conversion, digit 0 in [3:0]
//   o_bcd_valid    1-cycle pulse when o_bcd_out updates
//   o_wrap         1-cycle pulse on MAX_VAL->0 or 0->MAX_VAL
//   o_digit        BCD nibble of the selected digit (one cycle behind o_digit_sel)
//   o_digit_sel    digit index, 0 = least significant
//   o_digit_blank  1 = selected digit is a leading zero (BLANK_LZ=1 only)
module bcd_updown_counter_display #(
    parameter int DIGITS   = 4,
    parameter int BIN_W    = 14,
    parameter int MAX_VAL  = 9999,
    parameter int LOAD_W   = 8,
    parameter int TICK_DIV = 16777216,
    parameter int SCAN_DIV = 32768,
    parameter int BLANK_LZ = 1
) (
    input  logic                                       i_clk,
    input  logic                                       i_reset,
    input  logic                                       i_en,
    input  logic                                       i_up_dn,
    input  logic                                       i_load,
    input  logic [LOAD_W-1:0]                          i_load_val,
    output logic [BIN_W-1:0]                           o_count_bin,
    output logic [4*DIGITS-1:0]                        o_bcd_out,
    output logic                                       o_bcd_valid,
    output logic                                       o_wrap,
    output logic [3:0]                                 o_digit,
    output logic [((DIGITS > 1) ? $clog2(DIGITS) : 1)-1:0] o_digit_sel,
    output logic                                       o_digit_blank
);

    localparam int TW  = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int SW  = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DSW = (DIGITS > 1) ? $clog2(DIGITS) : 1;
    localparam int IW  = $clog2(BIN_W + 1);
    localparam int CW  = (LOAD_W > BIN_W) ? LOAD_W : BIN_W;
    localparam int WW  = 4*DIGITS + BIN_W;

    localparam logic [TW-1:0]    TICK_LAST = TW'(TICK_DIV - 1);
    localparam logic [SW-1:0]    SCAN_LAST = SW'(SCAN_DIV - 1);
    localparam logic [BIN_W-1:0] MAXV      = BIN_W'(MAX_VAL);
    localparam logic [CW-1:0]    MAXC      = CW'(MAX_VAL);

    typedef enum logic [1:0] {S_IDLE, S_ADJ, S_SHIFT, S_DONE} state_t;

    // ---------------- counter ----------------
    logic [TW-1:0]    r_tick_cnt;
    logic [BIN_W-1:0] r_count;
    logic             r_wrap;
    logic             r_req;      // count_bin was written last cycle
    logic             w_tick;
    logic [CW-1:0]    w_load_ext;
    logic [BIN_W-1:0] w_load_sat;

    assign w_tick = (r_tick_cnt == TICK_LAST);

    always_comb begin
        w_load_ext = CW'(i_load_val);
        w_load_sat = (w_load_ext > MAXC) ? MAXV : BIN_W'(w_load_ext);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_tick_cnt <= '0;
            r_count    <= '0;
            r_wrap     <= 1'b0;
            r_req      <= 1'b0;
        end else begin
            r_wrap <= 1'b0;
            r_req  <= 1'b0;
            if (i_load || w_tick)
                r_tick_cnt <= '0;
            else
                r_tick_cnt <= r_tick_cnt + TW'(1);

            if (i_load) begin
                r_count <= w_load_sat;
                r_req   <= 1'b1;
            end else if (w_tick && i_en) begin
                r_req <= 1'b1;
                if (i_up_dn) begin
                    if (r_count == MAXV) begin
                        r_count <= '0;
                        r_wrap  <= 1'b1;
                    end else begin
                        r_count <= r_count + BIN_W'(1);
                    end
                end else begin
                    if (r_count == '0) begin
                        r_count <= MAXV;
                        r_wrap  <= 1'b1;
                    end else begin
                        r_count <= r_count - BIN_W'(1);
                    end
                end
            end
        end
    end

    // ---------------- BCD converter ----------------
    state_t            r_state, w_state_next;
    logic [WW-1:0]     r_work, w_work_adj;
    logic [IW-1:0]     r_iter;
    logic              r_pending;
    logic [4*DIGITS-1:0] r_bcd_out;
    logic              r_bcd_valid;
    logic              w_snap, w_adj, w_shift, w_done;

    always_ff @(posedge i_clk) begin
        if (i_reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_next;
    end

    always_comb begin
        w_state_next = r_state;
        w_snap       = 1'b0;
        w_adj        = 1'b0;
        w_shift      = 1'b0;
        w_done       = 1'b0;
        case (r_state)
            S_IDLE: begin
                if (r_req) begin
                    w_snap       = 1'b1;
                    w_state_next = S_ADJ;
                end
            end
            S_ADJ: begin
                w_adj        = 1'b1;
                w_state_next = S_SHIFT;
            end
            S_SHIFT: begin
                w_shift      = 1'b1;
                w_state_next = (r_iter == IW'(BIN_W - 1)) ? S_DONE : S_ADJ;
            end
            S_DONE: begin
                w_done = 1'b1;
                // A request seen during conversion restarts immediately on the
                // latest count, skipping IDLE.
                if (r_pending || r_req) begin
                    w_snap       = 1'b1;
                    w_state_next = S_ADJ;
                end else begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        w_work_adj = r_work;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            if (r_work[BIN_W + 4*k +: 4] >= 4'd5)
                w_work_adj[BIN_W + 4*k +: 4] = r_work[BIN_W + 4*k +: 4] + 4'd3;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_work      <= '0;
            r_iter      <= '0;
            r_pending   <= 1'b0;
            r_bcd_out   <= '0;
            r_bcd_valid <= 1'b0;
        end else begin
            r_bcd_valid <= 1'b0;
            if (w_snap) begin
                r_work <= {{(4*DIGITS){1'b0}}, r_count};
                r_iter <= '0;
            end else if (w_adj) begin
                r_work <= w_work_adj;
            end else if (w_shift) begin
                r_work <= r_work << 1;
                r_iter <= r_iter + IW'(1);
            end
            if (w_done) begin
                r_bcd_out   <= r_work[WW-1 -: 4*DIGITS];
                r_bcd_valid <= 1'b1;
            end
            if (r_state == S_ADJ || r_state == S_SHIFT)
                r_pending <= r_pending | r_req;
            else
                r_pending <= 1'b0;
        end
    end

    // ---------------- display scan ----------------
    logic [SW-1:0]  r_scan_cnt;
    logic [DSW-1:0] r_digit_sel;
    logic [3:0]     r_digit, w_digit;
    logic           r_blank, w_blank, w_hi_zero;

    // Walk from the most significant digit down so w_hi_zero holds
    // "this digit and everything above it is zero" at the selected index.
    always_comb begin
        w_digit   = '0;
        w_blank   = 1'b0;
        w_hi_zero = 1'b1;
        for (int unsigned k = 0; k < DIGITS; k++) begin
            w_hi_zero = w_hi_zero & (r_bcd_out[4*(DIGITS-1-k) +: 4] == 4'd0);
            if (DSW'(DIGITS-1-k) == r_digit_sel) begin
                w_digit = r_bcd_out[4*(DIGITS-1-k) +: 4];
                w_blank = (BLANK_LZ != 0) && ((DIGITS-1-k) != 0) && w_hi_zero;
            end
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_scan_cnt  <= '0;
            r_digit_sel <= '0;
            r_digit     <= '0;
            r_blank     <= 1'b0;
        end else begin
            if (r_scan_cnt == SCAN_LAST) begin
                r_scan_cnt  <= '0;
                r_digit_sel <= (r_digit_sel == DSW'(DIGITS - 1)) ? '0 : r_digit_sel + DSW'(1);
            end else begin
                r_scan_cnt <= r_scan_cnt + SW'(1);
            end
            r_digit <= w_digit;
            r_blank <= w_blank;
        end
    end

    assign o_count_bin   = r_count;
    assign o_bcd_out     = r_bcd_out;
    assign o_bcd_valid   = r_bcd_valid;
    assign o_wrap        = r_wrap;
    assign o_digit       = r_digit;
    assign o_digit_sel   = r_digit_sel;
    assign o_digit_blank = r_blank;

endmodule

// File: tb/tb_bcd_updown_counter_display.sv
// Testbench for bcd_updown_counter_display: directed stimulus, expected BCD
// results queued when a count write is caused and checked on each bcd_valid.
module tb_bcd_updown_counter_display;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        reset, en, up_dn, load;
    logic [7:0]  load_val;
    logic [13:0] count_bin;
    logic [15:0] bcd_out;
    logic        bcd_valid, wrap, digit_blank;
    logic [3:0]  digit;
    logic [1:0]  digit_sel;

    logic        b_load;
    logic [7:0]  b_load_val;
    logic [13:0] b_count_bin;
    logic [15:0] b_bcd_out;
    logic        b_bcd_valid, b_wrap, b_digit_blank;
    logic [3:0]  b_digit;
    logic [1:0]  b_digit_sel;

    bcd_updown_counter_display #(.TICK_DIV(40), .SCAN_DIV(4)) dut (
        .i_clk(clk), .i_reset(reset), .i_en(en), .i_up_dn(up_dn),
        .i_load(load), .i_load_val(load_val),
        .o_count_bin(count_bin), .o_bcd_out(bcd_out), .o_bcd_valid(bcd_valid),
        .o_wrap(wrap), .o_digit(digit), .o_digit_sel(digit_sel),
        .o_digit_blank(digit_blank)
    );

    bcd_updown_counter_display #(.MAX_VAL(200), .TICK_DIV(40), .SCAN_DIV(4)) dut_b (
        .i_clk(clk), .i_reset(reset), .i_en(1'b0), .i_up_dn(1'b1),
        .i_load(b_load), .i_load_val(b_load_val),
        .o_count_bin(b_count_bin), .o_bcd_out(b_bcd_out), .o_bcd_valid(b_bcd_valid),
        .o_wrap(b_wrap), .o_digit(b_digit), .o_digit_sel(b_digit_sel),
        .o_digit_blank(b_digit_blank)
    );

    int n_tests = 0;
    int n_fail  = 0;
    int n_valid = 0;
    logic [15:0] sb[$];

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Scoreboard: every bcd_valid must match the oldest queued expectation.
    always @(negedge clk) begin
        if (bcd_valid === 1'b1) begin
            n_valid++;
            chk("sb_expected_pending", 32'(sb.size() != 0), 32'd1);
            if (sb.size() != 0)
                chk("sb_bcd_value", 32'(bcd_out), 32'(sb.pop_front()));
        end
    end

    task automatic do_load(input logic [7:0] v, input logic [15:0] exp_bcd);
        @(posedge clk); #1;
        load     = 1'b1;
        load_val = v;
        sb.push_back(exp_bcd);
        @(posedge clk); #1;
        load = 1'b0;
    endtask

    int          lat;
    int          vb;
    bit          found;
    logic [1:0]  prev;
    int exp_sel[4]   = '{1, 2, 3, 0};
    int exp_dig[4]   = '{4, 0, 0, 2};
    int exp_blank[4] = '{0, 1, 1, 0};

    initial begin
        reset = 1'b1; en = 1'b0; up_dn = 1'b1; load = 1'b0; load_val = '0;
        b_load = 1'b0; b_load_val = '0;

        // reset state
        repeat (3) @(posedge clk); #1;
        chk("rst_count", 32'(count_bin), 32'd0);
        chk("rst_bcd", 32'(bcd_out), 32'd0);
        chk("rst_valid", 32'(bcd_valid), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_digit", 32'(digit), 32'd0);
        chk("rst_sel", 32'(digit_sel), 32'd0);
        chk("rst_blank", 32'(digit_blank), 32'd0);
        reset = 1'b0;
        repeat (40) @(posedge clk); #1;
        chk("no_valid_after_reset", 32'(n_valid), 32'd0);

        // load 123, latency
        do_load(8'd123, 16'h0123);
        chk("load123_count", 32'(count_bin), 32'd123);
        lat = 0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge clk); #1;
            if (bcd_valid) begin
                lat = k;
                break;
            end
        end
        chk("conv_latency", 32'(lat), 32'd30);
        chk("load123_bcd", 32'(bcd_out), 32'h0123);
        @(posedge clk); #1;
        chk("valid_one_cycle", 32'(bcd_valid), 32'd0);

        // wrap in both directions
        do_load(8'd0, 16'h0000);
        en = 1'b1; up_dn = 1'b0;
        sb.push_back(16'h9999);
        repeat (40) @(posedge clk); #1;
        chk("down_wrap_count", 32'(count_bin), 32'd9999);
        chk("down_wrap_pulse", 32'(wrap), 32'd1);
        up_dn = 1'b1;
        sb.push_back(16'h0000);
        @(posedge clk); #1;
        chk("wrap_one_cycle", 32'(wrap), 32'd0);
        repeat (39) @(posedge clk); #1;
        chk("up_wrap_count", 32'(count_bin), 32'd0);
        chk("up_wrap_pulse", 32'(wrap), 32'd1);
        up_dn = 1'b0;
        sb.push_back(16'h9999);
        repeat (40) @(posedge clk); #1;
        chk("down_wrap2_count", 32'(count_bin), 32'd9999);
        chk("down_wrap2_pulse", 32'(wrap), 32'd1);
        en = 1'b0;
        repeat (35) @(posedge clk); #1;
        chk("down_wrap2_bcd", 32'(bcd_out), 32'h9999);

        // en=0 holds across three ticks
        vb = n_valid;
        repeat (120) @(posedge clk); #1;
        chk("hold_count", 32'(count_bin), 32'd9999);
        chk("hold_no_valid", 32'(n_valid), 32'(vb));

        // second load while converting
        vb = n_valid;
        do_load(8'd7, 16'h0007);
        repeat (4) @(posedge clk);
        do_load(8'd42, 16'h0042);
        repeat (70) @(posedge clk); #1;
        chk("two_loads_valid_count", 32'(n_valid), 32'(vb + 2));
        chk("two_loads_final_bcd", 32'(bcd_out), 32'h0042);
        chk("two_loads_count", 32'(count_bin), 32'd42);

        // scan of 0042
        found = 1'b0;
        prev  = digit_sel;
        for (int k = 0; k < 20; k++) begin
            @(posedge clk); #1;
            if (digit_sel == 2'd0 && prev != 2'd0) begin
                found = 1'b1;
                break;
            end
            prev = digit_sel;
        end
        chk("scan_sync", 32'(found), 32'd1);
        @(posedge clk); #1;
        chk("scan0_digit", 32'(digit), 32'd2);
        chk("scan0_blank", 32'(digit_blank), 32'd0);
        for (int i = 0; i < 4; i++) begin
            found = 1'b0;
            prev  = digit_sel;
            for (int k = 0; k < 10; k++) begin
                @(posedge clk); #1;
                if (digit_sel != prev) begin
                    found = 1'b1;
                    break;
                end
            end
            chk("scan_advance", 32'(found), 32'd1);
            chk("scan_sel", 32'(digit_sel), 32'(exp_sel[i]));
            @(posedge clk); #1;
            chk("scan_digit", 32'(digit), 32'(exp_dig[i]));
            chk("scan_blank", 32'(digit_blank), 32'(exp_blank[i]));
        end

        // saturating load with MAX_VAL=200
        @(posedge clk); #1;
        b_load = 1'b1; b_load_val = 8'd255;
        @(posedge clk); #1;
        b_load = 1'b0;
        chk("sat_count", 32'(b_count_bin), 32'd200);
        found = 1'b0;
        for (int k = 0; k < 40; k++) begin
            @(posedge clk); #1;
            if (b_bcd_valid) begin
                found = 1'b1;
                break;
            end
        end
        chk("sat_valid_seen", 32'(found), 32'd1);
        chk("sat_bcd", 32'(b_bcd_out), 32'h0200);

        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
